// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word serializer.
// Optional build macro: UART_SER_SYNC_HEADER_EN (adds the HEADER state).
package uart_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
`ifdef UART_SER_SYNC_HEADER_EN
      StHeader,
`endif
      StSend,
      StWaitAck,
      StWaitDone
   } ser_state_e;

endpackage

// File: rtl/uart_tx_word_serializer_if.sv
// Word-side valid/ready handshake feeding the serializer.
interface uart_tx_word_serializer_if #(
   parameter int unsigned WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with occupancy count; DEPTH must be a power of 2.
module uart_word_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [PW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr_q];
   assign count   = count_q;

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PW'(1);
         if (do_pop)  rptr_q <= rptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_tx_word_serializer.sv
// Buffers bus words and feeds them LSB byte first to the UART transmitter.
// Optional build macro: UART_SER_SYNC_HEADER_EN (sync byte 0xA5 before each word).
module uart_tx_word_serializer
   import uart_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_word_serializer_if.slave      bus,
   output logic [BYTE_W-1:0]             uart_data,
   output logic                          uart_data_en,
   input  logic                          uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);
   localparam int unsigned NUM_BYTES = WORD_WIDTH / BYTE_W;
   localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

   ser_state_e            state_q;
   logic [WORD_WIDTH-1:0] shift_q, shift_next, fifo_rdata;
   logic [CNT_W-1:0]      cnt_q;
   logic [BYTE_W-1:0]     data_q;
   logic                  fifo_full, fifo_empty, push, pop;
`ifdef UART_SER_SYNC_HEADER_EN
   logic                  hdr_q;
`endif

   assign bus.in_ready = !fifo_full;
   assign push         = bus.in_valid && !fifo_full;
   assign pop          = (state_q == StLoad);
   assign shift_next   = shift_q >> BYTE_W;
   assign uart_data    = data_q;
   assign busy         = !fifo_empty || (state_q != StIdle);

   // Strobe is qualified by the live tx_busy so it fires in the SEND cycle itself.
`ifdef UART_SER_SYNC_HEADER_EN
   assign uart_data_en = ((state_q == StSend) || (state_q == StHeader)) && !uart_tx_busy;
`else
   assign uart_data_en = (state_q == StSend) && !uart_tx_busy;
`endif

   uart_word_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (bus.in_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
`ifdef UART_SER_SYNC_HEADER_EN
         hdr_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty) state_q <= StLoad;
            end
            StLoad: begin
               shift_q <= fifo_rdata;
               cnt_q   <= LAST_IDX;
`ifdef UART_SER_SYNC_HEADER_EN
               data_q  <= SYNC_BYTE;
               hdr_q   <= 1'b1;
               state_q <= StHeader;
`else
               data_q  <= fifo_rdata[BYTE_W-1:0];
               state_q <= StSend;
`endif
            end
`ifdef UART_SER_SYNC_HEADER_EN
            StHeader: begin
               if (!uart_tx_busy) state_q <= StWaitAck;
            end
`endif
            StSend: begin
               if (!uart_tx_busy) state_q <= StWaitAck;
            end
            StWaitAck: begin
               if (uart_tx_busy) state_q <= StWaitDone;
            end
            StWaitDone: begin
               if (!uart_tx_busy) begin
`ifdef UART_SER_SYNC_HEADER_EN
                  if (hdr_q) begin
                     // Header done: first data byte is still at the bottom of shift_q.
                     hdr_q   <= 1'b0;
                     data_q  <= shift_q[BYTE_W-1:0];
                     state_q <= StSend;
                  end else
`endif
                  if (cnt_q == '0) begin
                     state_q <= StIdle;
                  end else begin
                     shift_q <= shift_next;
                     data_q  <= shift_next[BYTE_W-1:0];
                     cnt_q   <= cnt_q - CNT_W'(1);
                     state_q <= StSend;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
